// File: rtl/decode_stage_pkg.sv
// Shared pipeline definitions for the decode stage: ALU operations,
// stage-register structs and the opcode/funct7 constants.
package decode_stage_pkg;

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10
    } alu_op_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } IF_ID;

    typedef struct packed {
        alu_op_t     alu_op;
        logic [31:0] inst_imm;
        logic        input_a_is_immediate;
        logic [4:0]  reg_wr_addr;
        logic        reg_wr_en;
        logic [31:0] pc;
    } ID_EX;

    typedef struct packed {
        logic [4:0] reg_wr_addr;
        logic       reg_wr_en;
    } EX_WB;

    localparam ID_EX BUBBLE = '0;

    // funct3 mapping shared by OP-IMM and the base-funct7 OP encodings
    function automatic alu_op_t baseAluOp(input logic [2:0] funct3);
        case (funct3)
            3'b000:  baseAluOp = ALU_ADD;
            3'b001:  baseAluOp = ALU_SLL;
            3'b010:  baseAluOp = ALU_SLT;
            3'b011:  baseAluOp = ALU_SLTU;
            3'b100:  baseAluOp = ALU_XOR;
            3'b101:  baseAluOp = ALU_SRL;
            3'b110:  baseAluOp = ALU_OR;
            default: baseAluOp = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_hazard_unit.sv
// Read-after-write hazard compare against the two downstream writers.
module hazard_unit (
    input  logic [4:0] rs1_addr_i,
    input  logic       rs1_used_i,
    input  logic [4:0] rs2_addr_i,
    input  logic       rs2_used_i,
    input  logic [4:0] idex_wr_addr_i,
    input  logic       idex_wr_en_i,
    input  logic [4:0] exwb_wr_addr_i,
    input  logic       exwb_wr_en_i,
    output logic       hazard_o
);

    logic rs1Hit;
    logic rs2Hit;

    // x0 is never a real dependency, so a zero source address never hits
    always_comb begin
        rs1Hit = rs1_used_i && (rs1_addr_i != 5'd0) &&
                 ((idex_wr_en_i && (rs1_addr_i == idex_wr_addr_i)) ||
                  (exwb_wr_en_i && (rs1_addr_i == exwb_wr_addr_i)));
        rs2Hit = rs2_used_i && (rs2_addr_i != 5'd0) &&
                 ((idex_wr_en_i && (rs2_addr_i == idex_wr_addr_i)) ||
                  (exwb_wr_en_i && (rs2_addr_i == exwb_wr_addr_i)));
        hazard_o = rs1Hit || rs2Hit;
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes OP-IMM/OP/LUI into ID_EX, stalls on
// RAW hazards and flags illegal encodings with a bubble.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  IF_ID        if_id_reg,
    input  EX_WB        ex_wb_reg,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic        stall,
    output ID_EX        id_ex_reg,
    output logic        illegal_instr,
    output logic [15:0] stall_count
);

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    ID_EX        decoded;
    logic        legal;
    logic        rs1Used;
    logic        rs2Used;
    logic        hazardRaw;
    logic        isIllegal;

    ID_EX        idEx_d, idEx_q;
    logic        illegal_d, illegal_q;
    logic [15:0] stallCount_d, stallCount_q;

    assign instr  = if_id_reg.instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Immediate forms read their single source through port B, leaving A at x0
    always_comb begin
        decoded  = BUBBLE;
        legal    = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        rs1Used  = 1'b0;
        rs2Used  = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                legal                        = 1'b1;
                rs2_addr                     = instr[19:15];
                rs2Used                      = 1'b1;
                decoded.input_a_is_immediate = 1'b1;
                decoded.alu_op               = baseAluOp(funct3);
                decoded.inst_imm             = {{20{instr[31]}}, instr[31:20]};
                if (funct3 == 3'b001) begin
                    decoded.inst_imm = {27'd0, instr[24:20]};
                    legal            = (funct7 == F7_BASE);
                end else if (funct3 == 3'b101) begin
                    decoded.inst_imm = {27'd0, instr[24:20]};
                    if (funct7 == F7_ALT) begin
                        decoded.alu_op = ALU_SRA;
                    end else begin
                        legal = (funct7 == F7_BASE);
                    end
                end
            end
            OPC_OP: begin
                rs1_addr = instr[19:15];
                rs2_addr = instr[24:20];
                rs1Used  = 1'b1;
                rs2Used  = 1'b1;
                if (funct7 == F7_BASE) begin
                    legal          = 1'b1;
                    decoded.alu_op = baseAluOp(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    legal          = 1'b1;
                    decoded.alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    legal          = 1'b1;
                    decoded.alu_op = ALU_SRA;
                end
            end
            OPC_LUI: begin
                legal                        = 1'b1;
                decoded.alu_op               = ALU_ADD;
                decoded.inst_imm             = {instr[31:12], 12'h000};
                decoded.input_a_is_immediate = 1'b1;
            end
            default: ;
        endcase
        decoded.reg_wr_addr = instr[11:7];
        decoded.reg_wr_en   = (instr[11:7] != 5'd0);
        decoded.pc          = if_id_reg.pc;
    end

    hazard_unit u_hazard (
        .rs1_addr_i     (rs1_addr),
        .rs1_used_i     (rs1Used),
        .rs2_addr_i     (rs2_addr),
        .rs2_used_i     (rs2Used),
        .idex_wr_addr_i (idEx_q.reg_wr_addr),
        .idex_wr_en_i   (idEx_q.reg_wr_en),
        .exwb_wr_addr_i (ex_wb_reg.reg_wr_addr),
        .exwb_wr_en_i   (ex_wb_reg.reg_wr_en),
        .hazard_o       (hazardRaw)
    );

    // Illegal encodings win over hazards; anything not issuing becomes a bubble
    always_comb begin
        isIllegal    = if_id_reg.valid && !legal;
        stall        = if_id_reg.valid && legal && hazardRaw;
        idEx_d       = (if_id_reg.valid && legal && !hazardRaw) ? decoded : BUBBLE;
        illegal_d    = isIllegal;
        stallCount_d = stallCount_q;
        if (stall && stallCount_q != 16'hFFFF) begin
            stallCount_d = stallCount_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idEx_q       <= BUBBLE;
            illegal_q    <= 1'b0;
            stallCount_q <= 16'd0;
        end else begin
            idEx_q       <= idEx_d;
            illegal_q    <= illegal_d;
            stallCount_q <= stallCount_d;
        end
    end

    assign id_ex_reg     = idEx_q;
    assign illegal_instr = illegal_q;
    assign stall_count   = stallCount_q;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have ports: clk  input  1  clock, rising-edge active.
REQ-002 The block SHALL have ports: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have ports: if_id_reg  input  IF_ID  fetched instruction with fields instr[31:0], pc[31:0] and valid.
REQ-004 The block SHALL have ports: ex_wb_reg  input  EX_WB  downstream stage register, used for the hazard check only.
REQ-005 The block SHALL have ports: rs1_addr  output  5  register-file read port A address, combinational.
REQ-006 The block SHALL have ports: rs2_addr  output  5  register-file read port B address, combinational.
REQ-007 The block SHALL have ports: stall  output  1  combinational; holds the fetch stage and IF_ID when 1.
REQ-008 The block SHALL have ports: id_ex_reg  output  ID_EX  registered fields alu_op, inst_imm, input_a_is_immediate, reg_wr_addr, reg_wr_en and pc.
REQ-009 The block SHALL have ports: illegal_instr  output  1  registered one-cycle pulse.
REQ-010 The block SHALL have ports: stall_count  output  16  registered saturating count of stall cycles.

Function
REQ-011 Decode SHALL support exactly three opcode groups: OP-IMM (0010011), OP (0110011) and LUI (0110111).
REQ-012 OP-IMM: funct3 SHALL map 000 to ADD, 010 to SLT, 011 to SLTU, 100 to XOR, 110 to OR, 111 to AND, 001 to SLL (funct7 must be 0000000), and 101 to SRL (funct7 0000000) or SRA (funct7 0100000).
REQ-013 OP: funct7 0000000 SHALL map funct3 as in REQ-012, with 000 mapping to ADD; funct7 0100000 SHALL map funct3 000 to SUB and 101 to SRA; any other funct7/funct3 combination is illegal.
REQ-014 For immediate forms, inst_imm SHALL be the 32-bit sign extension of instr[31:20]; for shifts, inst_imm SHALL be the zero extension of instr[24:20].
REQ-015 For immediate forms, input_a_is_immediate SHALL be 1 and rs2_addr SHALL be instr[19:15]; rs1_addr SHALL be 0.
REQ-016 LUI SHALL decode as alu_op=ALU_ADD, inst_imm={instr[31:12],12'h000}, input_a_is_immediate=1, rs2_addr=0.
REQ-017 OP forms SHALL set input_a_is_immediate=0, rs1_addr=instr[19:15], rs2_addr=instr[24:20] and inst_imm=0.
REQ-018 For legal instructions, reg_wr_addr SHALL be instr[11:7], and reg_wr_en SHALL be 1 unless reg_wr_addr is 0.
REQ-019 A hazard SHALL exist when if_id_reg.valid is 1, the instruction reads a non-zero source address, and that address equals reg_wr_addr in either id_ex_reg or ex_wb_reg with the matching reg_wr_en set.
REQ-020 A hazard SHALL drive stall=1 in the same cycle.
REQ-021 On a hazard, id_ex_reg SHALL load a bubble on the next edge: alu_op=ALU_NONE, reg_wr_en=0, all other fields 0.
REQ-022 Latency SHALL be one cycle: a non-stalled valid instruction appears in id_ex_reg on the next rising edge.
REQ-023 When if_id_reg.valid is 0, the block SHALL load a bubble and drive stall=0.
REQ-024 An illegal instruction SHALL load a bubble, pulse illegal_instr for one cycle, and drive stall=0.
REQ-025 Hazard and illegal SHALL NOT both be asserted in the same cycle; the illegal check takes priority and no hazard is raised for an illegal instruction.
REQ-026 id_ex_reg.pc SHALL equal if_id_reg.pc for legal instructions and 0 for bubbles.
REQ-027 stall_count SHALL increment on every cycle with stall=1 and saturate at 16'hFFFF.

Reset
REQ-028 While reset_n is 0, id_ex_reg SHALL be all zeros (alu_op=ALU_NONE), illegal_instr SHALL be 0 and stall_count SHALL be 0.
REQ-029 Reset deassertion mid-stream SHALL produce a bubble on the first edge unless if_id_reg.valid is 1 with no hazard.
REQ-030 stall is combinational, so it SHALL remain 0 during reset only if if_id_reg.valid is 0; the fetch stage is responsible for holding valid low in reset.

Structure
REQ-031 The alu_op enum (ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA) SHALL live in the shared ALU enum header.
REQ-032 The IF_ID, ID_EX and EX_WB structs SHALL live in the shared pipeline-register definitions, as SHALL the opcode and funct7 constants.
REQ-033 The combinational hazard compare SHALL be a sub-module, hazard_unit, with inputs rs1/rs2 addresses, their use flags, and the two writer address/enable pairs, and a single hazard output.

Verification
REQ-034 The bench SHALL apply instr 0x00700293 (ADDI x5,x0,7) valid -> next cycle alu_op=ALU_ADD, inst_imm=7, reg_wr_addr=5, reg_wr_en=1, rs2_addr=0.
REQ-035 The bench SHALL apply 0x123450B7 (LUI x1,0x12345) -> inst_imm=0x12345000, input_a_is_immediate=1, reg_wr_addr=1.
REQ-036 The bench SHALL apply 0x402081B3 (SUB x3,x1,x2) -> alu_op=ALU_SUB, rs1_addr=1, rs2_addr=2, input_a_is_immediate=0.
REQ-037 The bench SHALL apply 0x00700293 then 0x00128313 (ADDI x6,x5,1) held under stall -> stall=1 for exactly 2 cycles, 2 bubbles, then the ADDI issues and stall_count=2.
REQ-038 The bench SHALL apply 0xFFFFFFFF valid -> illegal_instr=1 for one cycle, a bubble, and stall=0.
REQ-039 The bench SHALL assert reset_n=0 during a stall -> id_ex_reg all zeros, stall_count=0, and illegal_instr=0 immediately (asynchronous).
